// File: rtl/sample_capture_pkg.sv
// Shared sizing for the sample capture FIFO slice.
// Optional feature macro: SAMPLE_CAPTURE_FIFO_TIMESTAMP_EN adds a 32-bit push
// timestamp after the sample bytes of every entry.
package sample_capture_pkg;

  localparam int SC_OUTPUT_W     = 4;
  localparam int SC_COEFF_W      = 23;
  localparam int SC_WORD_W       = SC_OUTPUT_W * SC_COEFF_W;
  localparam int SC_WORD_BYTES   = (SC_WORD_W + 7) / 8;
  localparam int SC_TS_W         = 32;
  localparam int SC_DEPTH        = 16;
  localparam int SC_BYTECNT_SIZE = 7;

  // Number of host-readable bytes per entry for a given sample word size.
  function automatic int scTotalBytes(int wordBytes);
`ifdef SAMPLE_CAPTURE_FIFO_TIMESTAMP_EN
    return wordBytes + SC_TS_W / 8;
`else
    return wordBytes;
`endif
  endfunction

endpackage

// File: rtl/sample_capture_fifo_if.sv
// Sampler/host-side bundle of the sample capture FIFO.
// slave = the FIFO itself, master = whoever drives samples and host reads.
interface sample_capture_fifo_if
  import sample_capture_pkg::*;
#(
  parameter int pOUTPUT_W     = SC_OUTPUT_W,
  parameter int pCOEFF_W      = SC_COEFF_W,
  parameter int pDEPTH        = SC_DEPTH,
  parameter int pBYTECNT_SIZE = SC_BYTECNT_SIZE
) ();

  logic                            s_valid_i;
  logic                            s_ready_o;
  logic [pOUTPUT_W*pCOEFF_W-1:0]   s_data_i;
  logic [pBYTECNT_SIZE-1:0]        rd_bytecnt_i;
  logic [7:0]                      rd_data_o;
  logic                            pop_i;
  logic                            flush_i;
  logic [$clog2(pDEPTH):0]         count_o;
  logic                            empty_o;
  logic                            full_o;
  logic                            overflow_o;

  modport slave (
    input  s_valid_i, s_data_i, rd_bytecnt_i, pop_i, flush_i,
    output s_ready_o, rd_data_o, count_o, empty_o, full_o, overflow_o
  );

  modport master (
    output s_valid_i, s_data_i, rd_bytecnt_i, pop_i, flush_i,
    input  s_ready_o, rd_data_o, count_o, empty_o, full_o, overflow_o
  );

endinterface

// File: rtl/sample_capture_mem.sv
// Simple dual-port storage for the capture FIFO: synchronous write,
// asynchronous read so the top can register the selected byte itself.
module sample_capture_mem
  import sample_capture_pkg::*;
#(
  parameter int pDEPTH = SC_DEPTH,
  parameter int pWIDTH = SC_WORD_W,
  localparam int ADDR_W = $clog2(pDEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [pWIDTH-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [pWIDTH-1:0] rd_data_o
);

  logic [pWIDTH-1:0] mem_q [pDEPTH];

  // Write port: contents are not reset, only pointers/count give them meaning.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sample_capture_fifo.sv
// Sample capture FIFO between the sampler and the host register file.
// Host reads the head entry one byte at a time (1-cycle registered) and pops
// whole entries. Optional macro SAMPLE_CAPTURE_FIFO_TIMESTAMP_EN stores a
// free-running cycle count with each pushed word, readable as 4 extra bytes.
module sample_capture_fifo
  import sample_capture_pkg::*;
#(
  parameter int pOUTPUT_W     = SC_OUTPUT_W,
  parameter int pCOEFF_W      = SC_COEFF_W,
  parameter int pDEPTH        = SC_DEPTH,
  parameter int pBYTECNT_SIZE = SC_BYTECNT_SIZE
) (
  input  logic                  crypto_clk,
  input  logic                  reset_n_i,
  sample_capture_fifo_if.slave  bus
);

  localparam int WORD_W      = pOUTPUT_W * pCOEFF_W;
  localparam int WORD_BYTES  = (WORD_W + 7) / 8;
  localparam int TOTAL_BYTES = scTotalBytes(WORD_BYTES);
  localparam int PTR_W       = $clog2(pDEPTH);
  localparam int CNT_W       = PTR_W + 1;
`ifdef SAMPLE_CAPTURE_FIFO_TIMESTAMP_EN
  localparam int ENTRY_W     = WORD_W + SC_TS_W;
`else
  localparam int ENTRY_W     = WORD_W;
`endif

  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     overflow_q, overflow_d;
  logic [7:0]               rd_data_q, rd_data_d;
  logic                     full, empty, push, pop;
  logic [ENTRY_W-1:0]       wr_entry, head_entry;
  logic [TOTAL_BYTES*8-1:0] head_bytes;

  assign full  = (count_q == CNT_W'(pDEPTH));
  assign empty = (count_q == '0);

`ifdef SAMPLE_CAPTURE_FIFO_TIMESTAMP_EN
  logic [SC_TS_W-1:0] ts_q;

  // Free-running cycle counter that stamps each pushed word.
  always_ff @(posedge crypto_clk) begin
    if (!reset_n_i) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + SC_TS_W'(1);
    end
  end

  assign wr_entry = {ts_q, bus.s_data_i};
`else
  assign wr_entry = bus.s_data_i;
`endif

  sample_capture_mem #(
    .pDEPTH (pDEPTH),
    .pWIDTH (ENTRY_W)
  ) u_mem (
    .clk       (crypto_clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head_entry)
  );

  // Pointer/count/flag next state; flush wins over any push or pop.
  always_comb begin
    push       = bus.s_valid_i && !full && !bus.flush_i;
    pop        = bus.pop_i && !empty && !bus.flush_i;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (bus.s_valid_i && full) overflow_d = 1'b1;
    end
  end

  // Byte view of the head entry and selection of the requested byte.
  always_comb begin
    head_bytes = '0;
    head_bytes[WORD_W-1:0] = head_entry[WORD_W-1:0];
`ifdef SAMPLE_CAPTURE_FIFO_TIMESTAMP_EN
    head_bytes[WORD_BYTES*8 +: SC_TS_W] = head_entry[WORD_W +: SC_TS_W];
`endif
    rd_data_d = '0;
    if (!empty) begin
      for (int b = 0; b < TOTAL_BYTES; b++) begin
        if (bus.rd_bytecnt_i == pBYTECNT_SIZE'(b)) begin
          rd_data_d = head_bytes[b*8 +: 8];
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge crypto_clk) begin
    if (!reset_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.s_ready_o  = !full;
  assign bus.rd_data_o  = rd_data_q;
  assign bus.count_o    = count_q;
  assign bus.empty_o    = empty;
  assign bus.full_o     = full;
  assign bus.overflow_o = overflow_q;

endmodule

// File: tb/tb_sample_capture_fifo.sv
// Self-checking bench for sample_capture_fifo. A queue-based model tracks the
// FIFO contents, the sticky overflow flag and the timestamp counter; every
// clock is followed by a full comparison of the outputs plus directed checks.
module tb_sample_capture_fifo;

  localparam int DEPTH      = 16;
  localparam int WORD_W     = 92;
  localparam int WORD_BYTES = 12;
`ifdef SAMPLE_CAPTURE_FIFO_TIMESTAMP_EN
  localparam int TOTAL_BYTES = WORD_BYTES + 4;
`else
  localparam int TOTAL_BYTES = WORD_BYTES;
`endif

  typedef struct {
    logic [WORD_W-1:0] data;
    logic [31:0]       ts;
  } entry_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   assertCount = 0;
  int   failCount   = 0;

  entry_t      mq[$];
  bit          mOvf = 1'b0;
  logic [31:0] mTs  = '0;
  logic [7:0]  expRd = '0;

  sample_capture_fifo_if bus ();

  sample_capture_fifo dut (
    .crypto_clk (clk),
    .reset_n_i  (rstN),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] modelByte(int idx);
    logic [127:0] whole;
    whole = '0;
    if (mq.size() == 0 || idx >= TOTAL_BYTES) return 8'h00;
    whole[WORD_W-1:0] = mq[0].data;
`ifdef SAMPLE_CAPTURE_FIFO_TIMESTAMP_EN
    whole[WORD_BYTES*8 +: 32] = mq[0].ts;
`endif
    return whole[idx*8 +: 8];
  endfunction

  function automatic logic [WORD_W-1:0] randWord();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[WORD_W-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic step();
    bit doPush, doPop;
    @(posedge clk);
    expRd = rstN ? modelByte(int'(bus.rd_bytecnt_i)) : 8'h00;
    if (!rstN) begin
      mq.delete();
      mOvf = 1'b0;
      mTs  = '0;
    end else begin
      if (bus.flush_i) begin
        mq.delete();
        mOvf = 1'b0;
      end else begin
        doPop  = bus.pop_i && mq.size() > 0;
        doPush = bus.s_valid_i && mq.size() < DEPTH;
        if (bus.s_valid_i && mq.size() == DEPTH) mOvf = 1'b1;
        if (doPop) void'(mq.pop_front());
        if (doPush) mq.push_back('{bus.s_data_i, mTs});
      end
      mTs = mTs + 32'd1;
    end
    #1;
    checkOutput("count",    32'(bus.count_o),    32'(mq.size()));
    checkOutput("empty",    32'(bus.empty_o),    32'(mq.size() == 0));
    checkOutput("full",     32'(bus.full_o),     32'(mq.size() == DEPTH));
    checkOutput("ready",    32'(bus.s_ready_o),  32'(mq.size() != DEPTH));
    checkOutput("overflow", 32'(bus.overflow_o), 32'(mOvf));
    checkOutput("rd_data",  32'(bus.rd_data_o),  32'(expRd));
  endtask

  task automatic applyStimulus(input bit valid, input logic [WORD_W-1:0] data,
                               input bit pop, input bit flush, input int bytecnt);
    bus.s_valid_i    = valid;
    bus.s_data_i     = data;
    bus.pop_i        = pop;
    bus.flush_i      = flush;
    bus.rd_bytecnt_i = 7'(bytecnt);
    step();
  endtask

  task automatic idle(input int bytecnt);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, bytecnt);
  endtask

  initial begin
    logic [95:0] w;
    logic [WORD_W-1:0] wn;
    bus.s_valid_i = 1'b0; bus.s_data_i = '0; bus.pop_i = 1'b0;
    bus.flush_i = 1'b0; bus.rd_bytecnt_i = '0;

    // 1: reset, two pushes, byte reads, pop latency
    rstN = 1'b0;
    idle(0);
    idle(0);
    checkOutput("reset_count", 32'(bus.count_o), 32'd0);
    checkOutput("reset_rd",    32'(bus.rd_data_o), 32'd0);
    rstN = 1'b1;
    applyStimulus(1'b1, 92'h1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 92'hABC_DEF, 1'b0, 1'b0, 0);
    checkOutput("t1_count", 32'(bus.count_o), 32'd2);
    for (int b = 0; b < WORD_BYTES; b++) begin
      idle(b);
      checkOutput("t1_w0_byte", 32'(bus.rd_data_o), (b == 0) ? 32'h01 : 32'h00);
    end
    idle(20);
    idle(127);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);
    checkOutput("t1_pop_oldhead", 32'(bus.rd_data_o), 32'h01);
    idle(0);
    checkOutput("t1_newhead_b0", 32'(bus.rd_data_o), 32'hEF);
    idle(1);
    checkOutput("t1_newhead_b1", 32'(bus.rd_data_o), 32'hCD);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 2);
    checkOutput("t1_empty", 32'(bus.empty_o), 32'd1);

    // 2: fill to full, overflow, drain in order
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, randWord(), 1'b0, 1'b0, $urandom_range(0, 15));
    checkOutput("t2_full",  32'(bus.full_o),    32'd1);
    checkOutput("t2_ready", 32'(bus.s_ready_o), 32'd0);
    applyStimulus(1'b1, randWord(), 1'b0, 1'b0, 0);
    checkOutput("t2_ovf",   32'(bus.overflow_o), 32'd1);
    checkOutput("t2_count", 32'(bus.count_o),    32'd16);
    applyStimulus(1'b1, randWord(), 1'b1, 1'b0, 0);
    checkOutput("t2_fullpushpop", 32'(bus.count_o), 32'd15);
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(1'b0, '0, 1'b1, 1'b0, $urandom_range(0, 15));
    checkOutput("t2_empty", 32'(bus.empty_o), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 0);
    checkOutput("t2_flush_ovf", 32'(bus.overflow_o), 32'd0);

    // 3: steady push+pop at count 5, pointers wrap
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, randWord(), 1'b0, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, randWord(), 1'b1, 1'b0, $urandom_range(0, 13));
      checkOutput("t3_count", 32'(bus.count_o), 32'd5);
    end
    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < TOTAL_BYTES; b++) idle(b);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);
    end

    // 4: pop while empty, then push+pop while empty
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);
    checkOutput("t4_empty_pop", 32'(bus.count_o), 32'd0);
    w = '0;
    w[WORD_W-1:0] = randWord();
    applyStimulus(1'b1, w[WORD_W-1:0], 1'b1, 1'b0, 0);
    checkOutput("t4_count", 32'(bus.count_o), 32'd1);
    for (int b = 0; b < WORD_BYTES; b++) begin
      idle(b);
      checkOutput("t4_head", 32'(bus.rd_data_o), 32'(w[b*8 +: 8]));
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);

    // 5: flush with concurrent push, then reset mid-burst
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, randWord(), 1'b0, 1'b0, 0);
    applyStimulus(1'b1, randWord(), 1'b0, 1'b1, 0);
    checkOutput("t5_flush_count", 32'(bus.count_o), 32'd0);
    checkOutput("t5_flush_ovf",   32'(bus.overflow_o), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, randWord(), 1'b0, 1'b0, 0);
    rstN = 1'b0;
    applyStimulus(1'b1, randWord(), 1'b0, 1'b0, 0);
    rstN = 1'b1;
    checkOutput("t5_reset_count", 32'(bus.count_o), 32'd0);
    wn = randWord();
    applyStimulus(1'b1, wn, 1'b0, 1'b0, 0);
    idle(0);
    checkOutput("t5_new_head", 32'(bus.rd_data_o), 32'(wn[7:0]));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);

    // 6: timestamp bytes
`ifdef SAMPLE_CAPTURE_FIFO_TIMESTAMP_EN
    rstN = 1'b0;
    idle(0);
    rstN = 1'b1;
    for (int i = 0; i < 200 && mTs != 32'd100; i++) idle(0);
    checkOutput("t6_ts_sync", mTs, 32'd100);
    applyStimulus(1'b1, randWord(), 1'b0, 1'b0, 0);
    idle(0);
    idle(0);
    applyStimulus(1'b1, randWord(), 1'b0, 1'b0, 0);
    for (int b = 12; b < 16; b++) begin
      idle(b);
      checkOutput("t6_ts0", 32'(bus.rd_data_o), (b == 12) ? 32'h64 : 32'h00);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);
    for (int b = 12; b < 16; b++) begin
      idle(b);
      checkOutput("t6_ts1", 32'(bus.rd_data_o), (b == 12) ? 32'h67 : 32'h00);
    end
    idle(16);
    checkOutput("t6_past_end", 32'(bus.rd_data_o), 32'h00);
`else
    w = '1;
    applyStimulus(1'b1, w[WORD_W-1:0], 1'b0, 1'b0, 0);
    idle(11);
    checkOutput("t6_last_byte", 32'(bus.rd_data_o), 32'h0F);
    idle(12);
    checkOutput("t6_no_ts", 32'(bus.rd_data_o), 32'h00);
`endif
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
